cntr_wb_regs: RTL

Wishbone classic responder for the management SoC in the user project area. Holds a programmable up/down counter with prescaler, compare and wrap detection, and drives the count onto GPIO pads. Answers the initiator on `wbs_ack_o` / `wbs_dat_o`, the bus lines the current counter example leaves undriven. Raises `user_irq[0]` on match or wrap.

---
 rtl/cntr_wb_regs.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/cntr_wb_regs.sv
// cntr_wb_regs -- Wishbone classic responder holding a programmable up/down
// counter with optional prescaler, compare match and wrap detection.
//
// Optional feature macro: CNTR_WB_REGS_PRESCALER_EN
//   defined   : PRESC register (offset 0x14, 16 bits) and prescaler counter;
//               a tick fires when EN = 1 and the prescaler counter equals PRESC.
//   undefined : no prescaler; a tick fires every cycle while EN = 1, offset
//               0x14 reads 0 and writes to it are acked and ignored.
//
// Register map (byte offset from BASE_ADDR, unused bits read 0):
//   0x00 CTRL    bit0 EN, bit1 DIR (0 up / 1 down), bit2 IRQ_EN
//   0x04 LOAD    write loads the counter and stores the value
//   0x08 COUNT   read-only
//   0x0C COMPARE WIDTH bits
//   0x10 STATUS  bit0 MATCH, bit1 WRAP; sticky, write 1 to clear
//   0x14 PRESC   16 bits (prescaler builds only)
//   0x18..0xFF   acked, read 0, writes dropped
//
// Ports:
//   wb_clk_i, wb_rst_i     clock and synchronous active-high reset
//   wbs_cyc_i/stb_i/we_i   Wishbone classic cycle, strobe, write enable
//   wbs_sel_i              byte enables (honoured on writes)
//   wbs_adr_i, wbs_dat_i   byte address and write data
//   wbs_ack_o, wbs_dat_o   one-cycle acknowledge and registered read data
//   io_out, io_oeb         count on io_out[IO_LSB +: WIDTH]; oeb low there
//   user_irq               [0] = IRQ_EN & (MATCH | WRAP); [2:1] = 0
module cntr_wb_regs #(
    parameter int          WIDTH     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          IO_LSB    = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [37:0] io_out,
    output logic [37:0] io_oeb,
    output logic [2:0]  user_irq
);

    localparam logic [7:0] OFF_CTRL  = 8'h00;
    localparam logic [7:0] OFF_LOAD  = 8'h04;
    localparam logic [7:0] OFF_COUNT = 8'h08;
    localparam logic [7:0] OFF_CMP   = 8'h0C;
    localparam logic [7:0] OFF_STAT  = 8'h10;
    localparam logic [7:0] OFF_PRESC = 8'h14;

    localparam logic [37:0] CNT_MASK = ((38'd1 << WIDTH) - 38'd1) << IO_LSB;

    // Byte-lane merge of write data into an existing register value.
    function automatic logic [WIDTH-1:0] merge_cnt(input logic [WIDTH-1:0] old,
                                                   input logic [WIDTH-1:0] nw,
                                                   input logic [WIDTH-1:0] mask);
        return (old & ~mask) | (nw & mask);
    endfunction

    function automatic logic [15:0] merge16(input logic [15:0] old,
                                            input logic [15:0] nw,
                                            input logic [15:0] mask);
        return (old & ~mask) | (nw & mask);
    endfunction

    // One counter step, modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] count_step(input logic [WIDTH-1:0] c,
                                                    input logic down);
        return down ? c - WIDTH'(1) : c + WIDTH'(1);
    endfunction

    logic             ack;
    logic [31:0]      dat_q;
    logic             en;
    logic             dir;
    logic             irq_en;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] compare;
    logic             st_match;
    logic             st_wrap;

    logic             acc;
    logic             wr;
    logic [7:0]       off;
    logic [31:0]      be_mask;
    logic [31:0]      rdata;
    logic             wr_ctrl;
    logic             wr_load;
    logic             wr_cmp;
    logic             wr_stat;
    logic             tick;
    logic             step_en;
    logic [WIDTH-1:0] load_nx;
    logic [WIDTH-1:0] stepped;
    logic             wrap_set;
    logic             match_set;
    logic             unused_bits;

    // A new access is only taken when no ack is in flight, which gives the
    // classic one-idle-cycle gap when the strobe stays high.
    assign acc     = wbs_cyc_i & wbs_stb_i & ~ack & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign wr      = acc & wbs_we_i;
    assign off     = wbs_adr_i[7:0];
    assign be_mask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                      {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

    assign wr_ctrl = wr & (off == OFF_CTRL) & wbs_sel_i[0];
    assign wr_load = wr & (off == OFF_LOAD);
    assign wr_cmp  = wr & (off == OFF_CMP);
    assign wr_stat = wr & (off == OFF_STAT) & wbs_sel_i[0];

    assign load_nx = merge_cnt(load_val, wbs_dat_i[WIDTH-1:0], be_mask[WIDTH-1:0]);
    assign stepped = count_step(count, dir);

`ifdef CNTR_WB_REGS_PRESCALER_EN
    logic [15:0] presc;
    logic [15:0] pcnt;
    logic        wr_presc;

    assign wr_presc = wr & (off == OFF_PRESC);
    assign tick     = en & (pcnt == presc);
`else
    assign tick     = en;
`endif

    // A LOAD write in the same cycle as a tick wins; the tick is dropped
    // entirely, so it can raise neither WRAP nor MATCH.
    assign step_en   = tick & ~wr_load;
    assign wrap_set  = step_en & (dir ? (count == '0) : (count == '1));
    assign match_set = step_en & (stepped == compare);

    always_comb begin
        rdata = '0;
        case (off)
            OFF_CTRL:  rdata[2:0]       = {irq_en, dir, en};
            OFF_LOAD:  rdata[WIDTH-1:0] = load_val;
            OFF_COUNT: rdata[WIDTH-1:0] = count;
            OFF_CMP:   rdata[WIDTH-1:0] = compare;
            OFF_STAT:  rdata[1:0]       = {st_wrap, st_match};
`ifdef CNTR_WB_REGS_PRESCALER_EN
            OFF_PRESC: rdata[15:0]      = presc;
`endif
            default:   rdata            = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack      <= 1'b0;
            dat_q    <= '0;
            en       <= 1'b0;
            dir      <= 1'b0;
            irq_en   <= 1'b0;
            load_val <= '0;
            count    <= '0;
            compare  <= '0;
            st_match <= 1'b0;
            st_wrap  <= 1'b0;
`ifdef CNTR_WB_REGS_PRESCALER_EN
            presc    <= '0;
            pcnt     <= '0;
`endif
        end else begin
            ack   <= acc;
            // Read data reflects register state before this edge's updates.
            dat_q <= (acc & ~wbs_we_i) ? rdata : '0;

            if (wr_ctrl) begin
                {irq_en, dir, en} <= wbs_dat_i[2:0];
            end
            if (wr_load) begin
                load_val <= load_nx;
                count    <= load_nx;
            end else if (tick) begin
                count    <= stepped;
            end
            if (wr_cmp) begin
                compare <= merge_cnt(compare, wbs_dat_i[WIDTH-1:0], be_mask[WIDTH-1:0]);
            end

            // Set beats a same-cycle write-1-to-clear.
            st_match <= (st_match & ~(wr_stat & wbs_dat_i[0])) | match_set;
            st_wrap  <= (st_wrap  & ~(wr_stat & wbs_dat_i[1])) | wrap_set;

`ifdef CNTR_WB_REGS_PRESCALER_EN
            if (wr_presc) begin
                presc <= merge16(presc, wbs_dat_i[15:0], be_mask[15:0]);
            end
            // Held at 0 while disabled; restarts after each tick or load.
            if (~en | tick | wr_load) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + 16'd1;
            end
`endif
        end
    end

    always_comb begin
        io_out                  = '0;
        io_out[IO_LSB +: WIDTH] = count;
    end

    assign io_oeb    = ~CNT_MASK;
    assign user_irq  = {2'b00, irq_en & (st_match | st_wrap)};
    assign wbs_ack_o = ack;
    assign wbs_dat_o = dat_q;

    // Data and mask lanes above the register widths carry no state.
    assign unused_bits = ^{wbs_dat_i, be_mask};

endmodule
